// File: rtl/scan_selector.sv
// rtl/scan_selector.sv - registered N:1 channel selector with manual and dwell-timed auto scan
// Optional feature: define SCAN_MASK_EN to add the per-channel mask port for auto scan.
module scan_selector #(
   parameter int WIDTH    = 8,
   parameter int CHANNELS = 8,
   parameter int SEL_W    = 3,
   parameter int DWELL    = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [CHANNELS*WIDTH-1:0] options,
   input  logic [SEL_W-1:0]          choice,
   input  logic                      mode,
   input  logic                      hold,
`ifdef SCAN_MASK_EN
   input  logic [CHANNELS-1:0]       mask,
`endif
   output logic [WIDTH-1:0]          result,
   output logic [SEL_W-1:0]          cur_ch,
   output logic                      step
);

   localparam int                CNT_W    = (DWELL > 1) ? $clog2(DWELL) : 1;
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DWELL - 1);
   localparam logic [SEL_W:0]    CH_LIM   = (SEL_W + 1)'(CHANNELS);

   logic [CNT_W-1:0] cnt;
   logic [WIDTH-1:0] opt [CHANNELS];
   logic [SEL_W-1:0] nxt;
   logic [SEL_W-1:0] show;
   logic             any_en;
   logic             expire;

   for (genvar k = 0; k < CHANNELS; k++) begin : g_unpack
      assign opt[k] = options[k*WIDTH +: WIDTH];
   end

`ifdef SCAN_MASK_EN
   logic [SEL_W:0]   wide;
   logic [SEL_W-1:0] idx;
   logic             found;

   // Cyclic search starting just above cur_ch; i == CHANNELS lands back on cur_ch itself.
   always_comb begin
      nxt    = cur_ch;
      any_en = |mask;
      found  = 1'b0;
      wide   = '0;
      idx    = '0;
      for (int i = 1; i <= CHANNELS; i++) begin
         wide = {1'b0, cur_ch} + (SEL_W + 1)'(i);
         if (wide >= CH_LIM)
            wide = wide - CH_LIM;
         idx = wide[SEL_W-1:0];
         if (!found && mask[idx]) begin
            nxt   = idx;
            found = 1'b1;
         end
      end
   end
`else
   localparam logic [SEL_W-1:0] CH_LAST = SEL_W'(CHANNELS - 1);

   always_comb begin
      any_en = 1'b1;
      nxt    = (cur_ch == CH_LAST) ? '0 : cur_ch + 1'b1;
   end
`endif

   assign expire = (cnt == CNT_LAST);
   assign show   = expire ? nxt : cur_ch;

   always_ff @(posedge clk) begin
      if (rst) begin
         result <= '0;
         cur_ch <= '0;
         step   <= 1'b0;
         cnt    <= '0;
      end else if (hold) begin
         step <= 1'b0;
      end else if (!mode) begin
         cnt <= '0;
         if ({1'b0, choice} < CH_LIM) begin
            cur_ch <= choice;
            result <= opt[choice];
            step   <= (choice != cur_ch);
         end else begin
            step <= 1'b0;
         end
      end else begin
         cnt    <= expire ? '0 : cnt + 1'b1;
         cur_ch <= show;
         step   <= expire && (nxt != cur_ch);
         // Reload every cycle so live data on the shown channel is tracked.
         result <= any_en ? opt[show] : '0;
      end
   end

endmodule

// File: tb/tb_scan_selector.sv
// tb/tb_scan_selector.sv - directed vector bench for scan_selector (8-ch and 6-ch instances)
module tb_scan_selector;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_a, hold_a, mode_a;
   logic [2:0]  choice_a;
   logic [63:0] opt_a;
   logic [7:0]  res_a;
   logic [2:0]  cur_a;
   logic        step_a;

   logic        rst_b, hold_b, mode_b;
   logic [2:0]  choice_b;
   logic [47:0] opt_b;
   logic [7:0]  res_b;
   logic [2:0]  cur_b;
   logic        step_b;

`ifdef SCAN_MASK_EN
   logic [7:0]  mask_a;
   logic [5:0]  mask_b;
`endif

   scan_selector #(.WIDTH(8), .CHANNELS(8), .SEL_W(3), .DWELL(4)) dut_a (
      .clk     (clk),
      .rst     (rst_a),
      .options (opt_a),
      .choice  (choice_a),
      .mode    (mode_a),
      .hold    (hold_a),
`ifdef SCAN_MASK_EN
      .mask    (mask_a),
`endif
      .result  (res_a),
      .cur_ch  (cur_a),
      .step    (step_a)
   );

   scan_selector #(.WIDTH(8), .CHANNELS(6), .SEL_W(3), .DWELL(2)) dut_b (
      .clk     (clk),
      .rst     (rst_b),
      .options (opt_b),
      .choice  (choice_b),
      .mode    (mode_b),
      .hold    (hold_b),
`ifdef SCAN_MASK_EN
      .mask    (mask_b),
`endif
      .result  (res_b),
      .cur_ch  (cur_b),
      .step    (step_b)
   );

   typedef struct {
      bit         use_b;
      bit         rst;
      bit         hold;
      bit         mode;
      logic [2:0] choice;
      logic [7:0] e_res;
      logic [2:0] e_cur;
      bit         e_step;
   } vec_t;

   vec_t vt [14];
   int   n_vec = 0;
   int   n_bad = 0;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic chk_a(input string nm, input logic [7:0] er, input logic [2:0] ec, input bit es);
      check({nm, ".result"}, res_a, er);
      check({nm, ".cur_ch"}, cur_a, ec);
      check({nm, ".step"}, step_a, es);
   endtask

   task automatic reset_a(input bit m);
      rst_a  = 1'b1;
      mode_a = m;
      tick();
      rst_a  = 1'b0;
   endtask

   initial begin
      int e;
      rst_a = 0; hold_a = 0; mode_a = 0; choice_a = 0;
      rst_b = 0; hold_b = 0; mode_b = 0; choice_b = 0;
      for (int k = 0; k < 8; k++) opt_a[k*8 +: 8] = 8'h10 + 8'(k);
      for (int k = 0; k < 6; k++) opt_b[k*8 +: 8] = 8'h20 + 8'(k);
`ifdef SCAN_MASK_EN
      mask_a = 8'hFF;
      mask_b = 6'h3F;
`endif

      // use_b, rst, hold, mode, choice, exp result, exp cur_ch, exp step
      vt[0]  = '{0, 1, 0, 0, 3'd0, 8'h00, 3'd0, 0};
      vt[1]  = '{0, 0, 0, 0, 3'd5, 8'h15, 3'd5, 1};
      vt[2]  = '{0, 0, 0, 0, 3'd5, 8'h15, 3'd5, 0};
      vt[3]  = '{0, 0, 0, 0, 3'd2, 8'h12, 3'd2, 1};
      vt[4]  = '{0, 0, 1, 0, 3'd6, 8'h12, 3'd2, 0};
      vt[5]  = '{0, 0, 0, 0, 3'd6, 8'h16, 3'd6, 1};
      vt[6]  = '{0, 1, 1, 1, 3'd6, 8'h00, 3'd0, 0};
      vt[7]  = '{1, 1, 0, 0, 3'd0, 8'h00, 3'd0, 0};
      vt[8]  = '{1, 0, 0, 0, 3'd4, 8'h24, 3'd4, 1};
      vt[9]  = '{1, 0, 0, 0, 3'd7, 8'h24, 3'd4, 0};
      vt[10] = '{1, 0, 0, 0, 3'd6, 8'h24, 3'd4, 0};
      vt[11] = '{1, 0, 0, 0, 3'd2, 8'h22, 3'd2, 1};
      vt[12] = '{1, 0, 1, 0, 3'd5, 8'h22, 3'd2, 0};
      vt[13] = '{1, 0, 0, 0, 3'd5, 8'h25, 3'd5, 1};

      for (int v = 0; v < 14; v++) begin
         if (vt[v].use_b) begin
            rst_b = vt[v].rst; hold_b = vt[v].hold; mode_b = vt[v].mode; choice_b = vt[v].choice;
         end else begin
            rst_a = vt[v].rst; hold_a = vt[v].hold; mode_a = vt[v].mode; choice_a = vt[v].choice;
         end
         tick();
         if (vt[v].use_b) begin
            check($sformatf("vec%0d.result", v), res_b, vt[v].e_res);
            check($sformatf("vec%0d.cur_ch", v), cur_b, vt[v].e_cur);
            check($sformatf("vec%0d.step", v), step_b, vt[v].e_step);
         end else begin
            check($sformatf("vec%0d.result", v), res_a, vt[v].e_res);
            check($sformatf("vec%0d.cur_ch", v), cur_a, vt[v].e_cur);
            check($sformatf("vec%0d.step", v), step_a, vt[v].e_step);
         end
      end
      rst_a = 0; hold_a = 0; rst_b = 0; hold_b = 0;

      // auto scan with wrap: channel c/4, step on every 4th edge
      reset_a(1);
      for (int c = 1; c <= 32; c++) begin
         tick();
         e = (c / 4) % 8;
         chk_a($sformatf("scan%0d", c), 8'h10 + 8'(e), 3'(e), (c % 4) == 0);
      end

      // hold for 3 cycles at dwell count 2 on channel 3
      reset_a(1);
      repeat (14) tick();
      chk_a("hold_pre", 8'h13, 3'd3, 0);
      hold_a = 1;
      opt_a[3*8 +: 8] = 8'hAA;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk_a($sformatf("hold%0d", i), 8'h13, 3'd3, 0);
      end
      hold_a = 0;
      tick();
      chk_a("hold_rel", 8'hAA, 3'd3, 0);
      opt_a[3*8 +: 8] = 8'h13;
      tick();
      chk_a("hold_adv", 8'h14, 3'd4, 1);

      // reset mid-scan on channel 6, dwell count 1
      reset_a(1);
      repeat (25) tick();
      chk_a("mid_pre", 8'h16, 3'd6, 0);
      rst_a = 1;
      tick();
      chk_a("mid_rst", 8'h00, 3'd0, 0);
      rst_a = 0;
      for (int i = 1; i <= 4; i++) begin
         tick();
         chk_a($sformatf("mid_after%0d", i), (i == 4) ? 8'h11 : 8'h10, (i == 4) ? 3'd1 : 3'd0, i == 4);
      end

      // manual -> auto continues from cur_ch, auto -> manual honours choice
      reset_a(0);
      choice_a = 5;
      tick();
      chk_a("man5", 8'h15, 3'd5, 1);
      mode_a = 1;
      for (int i = 1; i <= 4; i++) begin
         tick();
         chk_a($sformatf("m2a%0d", i), (i == 4) ? 8'h16 : 8'h15, (i == 4) ? 3'd6 : 3'd5, i == 4);
      end
      mode_a = 0;
      choice_a = 2;
      tick();
      chk_a("a2m", 8'h12, 3'd2, 1);

`ifdef SCAN_MASK_EN
      mask_a = 8'b1010_0100;
      reset_a(1);
      for (int c = 1; c <= 16; c++) begin
         tick();
         case (c / 4)
            0:       e = 0;
            1:       e = 2;
            2:       e = 5;
            3:       e = 7;
            default: e = 2;
         endcase
         chk_a($sformatf("mask%0d", c), 8'h10 + 8'(e), 3'(e), (c % 4) == 0);
      end
      mask_a = 8'h00;
      for (int i = 0; i < 6; i++) begin
         tick();
         chk_a($sformatf("mask0_%0d", i), 8'h00, 3'd2, 0);
      end
      mask_a = 8'hFF;
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
